// File: rtl/fencei_rsp_pkg.sv
// Shared types and helpers for the fence.i flush responder.
// Holds the FSM state encoding, the LFSR feedback taps and the latency clamp.
package fencei_rsp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    ACK,
    WAIT_LOW
  } fencei_rsp_state_e;

  // Taps 16,14,13,11 expressed for a right-shifting register: bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int unsigned clamp_lat(input int unsigned r,
                                            input int unsigned min_lat,
                                            input int unsigned max_lat);
    int unsigned lat;
    lat = min_lat + r;
    return (lat > max_lat) ? max_lat : lat;
  endfunction

endpackage

// File: rtl/fencei_flush_responder_if.sv
// fence.i flush request/acknowledge handshake between core and I-fetch side.
// The core is the master (drives req); the responder is the slave (drives ack).
interface fencei_flush_responder_if;

  logic flush_req;
  logic flush_ack;

  modport master (output flush_req, input flush_ack);
  modport slave  (input flush_req, output flush_ack);

endinterface

// File: rtl/fencei_lfsr.sv
// Free-running 16-bit Fibonacci LFSR that advances every cycle.
// Exposes only the low OUT_W bits used as the raw random latency.
module fencei_lfsr
  import fencei_rsp_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic [OUT_W-1:0] rnd_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/fencei_flush_responder.sv
// fence.i flush responder: acks each core flush request after a fixed or
// pseudo-random latency, flags handshake violations and counts completed flushes.
module fencei_flush_responder
  import fencei_rsp_pkg::*;
#(
  parameter int unsigned LAT_W     = 8,
  parameter int unsigned MIN_LAT   = 0,
  parameter int unsigned MAX_LAT   = 15,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  fencei_flush_responder_if.slave fencei,
  input  logic                  cfg_rand_i,
  input  logic [LAT_W-1:0]      cfg_lat_i,
  output logic                  busy_o,
  output logic                  proto_err_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam int unsigned RANGE      = MAX_LAT - MIN_LAT + 1;
  localparam int unsigned RANGE_BITS = $clog2(RANGE);
  localparam logic [LAT_W-1:0] RANGE_MASK = LAT_W'((64'd1 << RANGE_BITS) - 64'd1);

  fencei_rsp_state_e state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              err_seen_q, err_seen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [LAT_W-1:0]  rnd;
  logic [LAT_W-1:0]  rand_lat;

  fencei_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (LAT_W)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .rnd_o (rnd)
  );

  assign rand_lat = LAT_W'(clamp_lat(32'(rnd & RANGE_MASK), MIN_LAT, MAX_LAT));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    err_seen_d = err_seen_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (fencei.flush_req) begin
          state_d   = COUNT;
          lat_cnt_d = cfg_rand_i ? rand_lat : cfg_lat_i;
        end
      end
      COUNT: begin
        // A dropped request wins over a counter that just reached zero.
        if (!fencei.flush_req) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (lat_cnt_q == '0) begin
          state_d = ACK;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      ACK: begin
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!fencei.flush_req) begin
          state_d    = IDLE;
          err_seen_d = 1'b0;
        end else if (!err_seen_q) begin
          err_d      = 1'b1;
          err_seen_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      err_seen_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      err_seen_q <= err_seen_d;
      cnt_q      <= cnt_d;
    end
  end

  assign fencei.flush_ack = ack_q;
  assign busy_o           = (state_q == COUNT) || (state_q == ACK);
  assign proto_err_o      = err_q;
  assign flush_cnt_o      = cnt_q;

endmodule

// File: tb/tb_fencei_flush_responder.sv
// Directed self-checking bench for fencei_flush_responder (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_fencei_flush_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_rand;
  logic [7:0]  cfg_lat;
  logic        busy;
  logic        proto_err;
  logic [31:0] flush_cnt;

  int vectors     = 0;
  int miscompares = 0;

  int run1 [1000];
  int got;
  int exp_l;

  logic [15:0] lfsr_m;

  fencei_flush_responder_if bus ();

  fencei_flush_responder dut (
    .clk         (clk),
    .reset       (reset),
    .fencei      (bus),
    .cfg_rand_i  (cfg_rand),
    .cfg_lat_i   (cfg_lat),
    .busy_o      (busy),
    .proto_err_o (proto_err),
    .flush_cnt_o (flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference LFSR: seed 16'hACE1, taps 16,14,13,11, shifting right.
  always @(posedge clk) begin
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise req, measure cycles to ack, drop req, return to IDLE.
  task automatic run_req(input int exp_lat, input string tag, output int got_lat);
    bus.flush_req = 1'b1;
    got_lat = -1;
    for (int n = 0; n < 40 && got_lat < 0; n++) begin
      @(negedge clk);
      if (bus.flush_ack) got_lat = n - 1;
    end
    check({tag, "_lat"}, 32'(got_lat), 32'(exp_lat));
    bus.flush_req = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, bus.flush_ack}, 32'd0);
    check({tag, "_noerr"}, {31'd0, proto_err}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b1;
    bus.flush_req = 1'b0;
    cfg_rand      = 1'b0;
    cfg_lat       = 8'd0;
    step(3);

    // Reset values
    check("rst_ack",  {31'd0, bus.flush_ack}, 32'd0);
    check("rst_busy", {31'd0, busy},          32'd0);
    check("rst_err",  {31'd0, proto_err},     32'd0);
    check("rst_cnt",  flush_cnt,              32'd0);
    reset = 1'b0;
    step(2);

    // Fixed latency 0: ack in the cycle after the accepting edge only
    cfg_lat = 8'd0;
    bus.flush_req = 1'b1;
    step(1);
    check("l0_ack_n0", {31'd0, bus.flush_ack}, 32'd0);
    step(1);
    check("l0_ack_n1", {31'd0, bus.flush_ack}, 32'd1);
    check("l0_cnt",    flush_cnt,              32'd1);
    bus.flush_req = 1'b0;
    step(1);
    check("l0_ack_n2", {31'd0, bus.flush_ack}, 32'd0);
    step(1);
    check("l0_busy_n3", {31'd0, busy},      32'd0);
    check("l0_err_n3",  {31'd0, proto_err}, 32'd0);

    // Fixed latency 5: ack at k+6, busy through k+1..k+6
    cfg_lat = 8'd5;
    bus.flush_req = 1'b1;
    step(1);
    for (int n = 1; n <= 6; n++) begin
      step(1);
      check("l5_busy", {31'd0, busy},          32'd1);
      check("l5_ack",  {31'd0, bus.flush_ack}, (n == 6) ? 32'd1 : 32'd0);
    end
    bus.flush_req = 1'b0;
    step(1);
    check("l5_busy_after", {31'd0, busy},          32'd0);
    check("l5_ack_after",  {31'd0, bus.flush_ack}, 32'd0);
    check("l5_cnt",        flush_cnt,              32'd2);
    check("l5_err",        {31'd0, proto_err},     32'd0);
    step(1);

    // Abort: req dropped two cycles into a 5-cycle latency
    cfg_lat = 8'd5;
    bus.flush_req = 1'b1;
    step(2);
    bus.flush_req = 1'b0;
    step(1);
    check("abort_err",  {31'd0, proto_err},     32'd1);
    check("abort_busy", {31'd0, busy},          32'd0);
    check("abort_ack",  {31'd0, bus.flush_ack}, 32'd0);
    step(1);
    check("abort_err_once", {31'd0, proto_err},     32'd0);
    check("abort_ack2",     {31'd0, bus.flush_ack}, 32'd0);
    check("abort_cnt",      flush_cnt,              32'd2);

    // Req held three cycles past ack
    cfg_lat = 8'd1;
    bus.flush_req = 1'b1;
    step(2);
    check("hold_ack_n1", {31'd0, bus.flush_ack}, 32'd0);
    step(1);
    check("hold_ack_n2", {31'd0, bus.flush_ack}, 32'd1);
    check("hold_cnt",    flush_cnt,              32'd3);
    step(1);
    check("hold_err_n3", {31'd0, proto_err},     32'd0);
    step(1);
    check("hold_err_n4", {31'd0, proto_err},     32'd1);
    step(1);
    check("hold_err_n5", {31'd0, proto_err},     32'd0);
    check("hold_ack_n5", {31'd0, bus.flush_ack}, 32'd0);
    bus.flush_req = 1'b0;
    step(1);
    check("hold_err_n6", {31'd0, proto_err},     32'd0);
    check("hold_cnt2",   flush_cnt,              32'd3);
    cfg_lat = 8'd2;
    run_req(2, "after_hold", got);
    check("after_hold_cnt", flush_cnt, 32'd4);

    // Reset in COUNT with three cycles remaining
    cfg_lat = 8'd5;
    bus.flush_req = 1'b1;
    step(3);
    reset = 1'b1;
    bus.flush_req = 1'b0;
    step(1);
    check("rc_ack",  {31'd0, bus.flush_ack}, 32'd0);
    check("rc_busy", {31'd0, busy},          32'd0);
    check("rc_err",  {31'd0, proto_err},     32'd0);
    check("rc_cnt",  flush_cnt,              32'd0);
    reset    = 1'b0;
    cfg_rand = 1'b1;
    // LFSR back at 16'hACE1: low nibble 1 gives latency 1
    run_req(1, "rc_seed", got);
    check("rc_seed_cnt", flush_cnt, 32'd1);

    // Random mode, two runs of 1000 requests from the same seed
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      exp_l = int'(lfsr_m[3:0]);
      run_req(exp_l, "rand1", got);
      run1[i] = got;
      check("rand1_range", {31'd0, (got >= 0 && got <= 15)}, 32'd1);
    end
    check("rand1_cnt", flush_cnt, 32'd1000);

    reset = 1'b1;
    step(2);
    reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      exp_l = int'(lfsr_m[3:0]);
      run_req(exp_l, "rand2", got);
      check("rand_repeat", 32'(got), 32'(run1[i]));
    end
    check("rand2_cnt", flush_cnt, 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
